// File: rtl/card_dealer_pkg.sv
// Shared card/dealer types, deck constants and the mod-13 reduction step.
package card_pkg;

    localparam int unsigned RANK_MIN  = 1;
    localparam int unsigned RANK_MAX  = 13;
    localparam int unsigned SUITS     = 4;
    localparam int unsigned DECK_SIZE = 52;

    typedef logic [3:0] rank_t;

    typedef enum logic [1:0] {IDLE, REDUCE, CHECK, DONE} dealer_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One restoring step: shift in the next bit, subtract 13 if it fits.
    function automatic logic [3:0] mod13_step(input logic [3:0] rem, input logic bit_in);
        logic [4:0] t;
        t = {rem, bit_in};
        return (t >= 5'd13) ? 4'(t - 5'd13) : t[3:0];
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/response bundle between the game logic and the card dealer.
interface card_dealer_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DECKS = 1
);
    localparam int unsigned RW = $clog2(52 * DECKS + 1);

    logic [WIDTH-1:0] i_Count;
    logic             i_Draw;
    logic             i_NewDeck;
    logic             o_Busy;
    logic [3:0]       o_Card;
    logic             o_Valid;
    logic             o_Empty;
    logic [RW-1:0]    o_Remaining;

    modport master (
        output i_Count, i_Draw, i_NewDeck,
        input  o_Busy, o_Card, o_Valid, o_Empty, o_Remaining
    );

    modport slave (
        input  i_Count, i_Draw, i_NewDeck,
        output o_Busy, o_Card, o_Valid, o_Empty, o_Remaining
    );
endinterface

// File: rtl/card_dealer_mod13_reducer.sv
// Iterative value mod 13, one bit per cycle MSB first; done pulses WIDTH cycles after start.
module mod13_reducer
    import card_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             done,
    output logic [3:0]       remainder
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       rem_q;

    // The MSB is consumed on the start edge, so WIDTH-1 further steps remain.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= mod13_step(4'd0, value[WIDTH-1]);
                sh_q   <= value << 1;
                cnt_q  <= CW'(WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= mod13_step(rem_q, sh_q[WIDTH-1]);
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign remainder = rem_q;

endmodule

// File: rtl/card_dealer.sv
// Deals ranks 1..13 without replacement from a tracked shoe, seeded by the game counter.
// Define DEALER_LFSR_EN to whiten the sampled counter with a free-running 16-bit LFSR.
module card_dealer
    import card_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DECKS = 1
) (
    input  logic         clk_50M,
    input  logic         i_Reset,
    card_dealer_if.slave bus
);
    localparam int unsigned CW = $clog2(SUITS * DECKS + 1);
    localparam int unsigned RW = $clog2(DECK_SIZE * DECKS + 1);

    dealer_state_t    state_q;
    rank_t            rank_q;
    logic [CW-1:0]    cnt_q [RANK_MIN:RANK_MAX];
    logic [RW-1:0]    remaining_q;
    rank_t            card_q;
    logic             valid_q;
    logic             busy_q;
    logic             empty_q;
    logic [WIDTH-1:0] sample_d;
    logic             start_d;
    logic             red_done;
    logic [3:0]       red_rem;

`ifdef DEALER_LFSR_EN
    logic [15:0] lfsr_q;

    // x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign sample_d = bus.i_Count ^ lfsr_q[WIDTH-1:0];
`else
    assign sample_d = bus.i_Count;
`endif

    // DONE already has o_Busy low, so it accepts a new draw just like IDLE.
    assign start_d = ((state_q == IDLE) || (state_q == DONE)) &&
                     bus.i_Draw && !empty_q && !bus.i_NewDeck;

    mod13_reducer #(.WIDTH(WIDTH)) u_reducer (
        .clk_50M   (clk_50M),
        .i_Reset   (i_Reset),
        .start     (start_d),
        .value     (sample_d),
        .done      (red_done),
        .remainder (red_rem)
    );

    always_ff @(posedge clk_50M) begin
        if (i_Reset || bus.i_NewDeck) begin
            for (int unsigned r = RANK_MIN; r <= RANK_MAX; r++) cnt_q[r] <= CW'(SUITS * DECKS);
            remaining_q <= RW'(DECK_SIZE * DECKS);
            state_q     <= IDLE;
            rank_q      <= rank_t'(RANK_MIN);
            card_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_d) begin
                        state_q <= REDUCE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REDUCE: begin
                    if (red_done) begin
                        rank_q  <= rank_t'(red_rem) + rank_t'(1);
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cnt_q[rank_q] != '0) begin
                        cnt_q[rank_q] <= cnt_q[rank_q] - CW'(1);
                        remaining_q   <= remaining_q - RW'(1);
                        empty_q       <= (remaining_q == RW'(1));
                        card_q        <= rank_q;
                        valid_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= DONE;
                    end else begin
                        rank_q <= (rank_q == rank_t'(RANK_MAX)) ? rank_t'(RANK_MIN)
                                                                : rank_q + rank_t'(1);
                    end
                end
            endcase
        end
    end

    assign bus.o_Busy      = busy_q;
    assign bus.o_Card      = card_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Empty     = empty_q;
    assign bus.o_Remaining = remaining_q;

endmodule

// File: tb/tb_card_dealer.sv
// Table-driven and scoreboard checks of card_dealer (WIDTH=12, DECKS=1).
module tb_card_dealer;
    localparam int unsigned W = 12;
    localparam int unsigned D = 1;

    logic clk_50M = 1'b0;
    logic i_Reset;

    always #10 clk_50M = ~clk_50M;

    card_dealer_if #(.WIDTH(W), .DECKS(D)) bus ();

    card_dealer #(.WIDTH(W), .DECKS(D)) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    typedef struct {bit rst_before; int count; int card; int lat;} vec_t;
    typedef struct {int card; int lat; int rem;} exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   m_cnt[14];
    int   m_rem;
    int   tally[14];
    int   vectors = 0;
    int   miscompares = 0;

`ifdef DEALER_LFSR_EN
    logic [15:0] m_lfsr;
    always @(posedge clk_50M) begin
        if (i_Reset) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
`endif

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing at %0t", name, $time);
    endtask

    function automatic void model_refill();
        for (int r = 1; r <= 13; r++) m_cnt[r] = 4 * D;
        m_rem = 52 * D;
    endfunction

    // Reference deal: plain modulo, then linear probe to the next non-empty rank.
    function automatic exp_t model_draw(input int cnt);
        exp_t e;
        int   s;
        int   r;
        int   probes;
        s = cnt;
`ifdef DEALER_LFSR_EN
        s = cnt ^ int'(m_lfsr[W-1:0]);
`endif
        r = (s % 13) + 1;
        probes = 0;
        while (m_cnt[r] == 0 && probes < 13) begin
            r = (r == 13) ? 1 : r + 1;
            probes++;
        end
        m_cnt[r]--;
        m_rem--;
        e.card = r;
        e.lat  = W + 2 + probes;
        e.rem  = m_rem;
        return e;
    endfunction

    // Runs cycles after a drive point; k=1 is the cycle after it. Pops the scoreboard on every o_Valid.
    task automatic watch(input int cycles, input bit stop_on_valid, input int draw_at,
                         input int nd_at, input int rst_at, output int nvalid, output int lat);
        exp_t e;
        nvalid = 0;
        lat    = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk_50M);
            #1;
            bus.i_Draw    = (k == draw_at);
            bus.i_NewDeck = (k == nd_at);
            i_Reset       = (k == rst_at);
            if (k == 1 && sb.size() > 0) chk("busy_after_draw", int'(bus.o_Busy), 1);
            if (bus.o_Valid) begin
                nvalid++;
                lat = k;
                if (int'(bus.o_Card) < 14) tally[int'(bus.o_Card)]++;
                if (sb.size() == 0) begin
                    fail("unexpected_valid");
                end else begin
                    e = sb.pop_front();
                    chk("card", int'(bus.o_Card), e.card);
                    chk("latency", k, e.lat);
                    chk("remaining", int'(bus.o_Remaining), e.rem);
                    chk("busy_at_valid", int'(bus.o_Busy), 0);
                    chk("empty_at_valid", int'(bus.o_Empty), (e.rem == 0) ? 1 : 0);
                end
                if (stop_on_valid) return;
            end
        end
    endtask

    task automatic do_reset();
        i_Reset       = 1'b1;
        bus.i_Draw    = 1'b0;
        bus.i_NewDeck = 1'b0;
        repeat (2) @(posedge clk_50M);
        #1;
        i_Reset = 1'b0;
        model_refill();
        sb.delete();
        for (int r = 0; r < 14; r++) tally[r] = 0;
    endtask

    task automatic do_draw(input int cnt, output int card, output int lat);
        int n;
        bus.i_Count = W'(cnt);
        bus.i_Draw  = 1'b1;
        sb.push_back(model_draw(cnt));
        watch(40, 1'b1, 0, 0, 0, n, lat);
        if (n == 0) begin
            fail("draw_timeout");
            sb.delete();
        end
        card = int'(bus.o_Card);
    endtask

    task automatic chk_idle_refilled(input string tag);
        chk({tag, "_card"}, int'(bus.o_Card), 0);
        chk({tag, "_valid"}, int'(bus.o_Valid), 0);
        chk({tag, "_busy"}, int'(bus.o_Busy), 0);
        chk({tag, "_empty"}, int'(bus.o_Empty), 0);
        chk({tag, "_remaining"}, int'(bus.o_Remaining), 52);
    endtask

    initial begin
        int card;
        int lat;
        int n;

        vecs[0] = '{1'b1, 0,    1,  14};
        vecs[1] = '{1'b0, 25,   13, 14};
        vecs[2] = '{1'b0, 4095, 1,  14};
        vecs[3] = '{1'b0, 12,   13, 14};
        vecs[4] = '{1'b1, 0,    1,  14};
        vecs[5] = '{1'b0, 0,    1,  14};
        vecs[6] = '{1'b0, 0,    1,  14};
        vecs[7] = '{1'b0, 0,    1,  14};
        vecs[8] = '{1'b0, 0,    2,  15};

        i_Reset       = 1'b1;
        bus.i_Count   = '0;
        bus.i_Draw    = 1'b0;
        bus.i_NewDeck = 1'b0;
        do_reset();
        chk_idle_refilled("reset");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst_before) do_reset();
            do_draw(vecs[i].count, card, lat);
`ifndef DEALER_LFSR_EN
            chk("tbl_card", card, vecs[i].card);
            chk("tbl_latency", lat, vecs[i].lat);
`endif
        end

        // Drain a full shoe with random entropy.
        do_reset();
        for (int i = 0; i < 52; i++) do_draw(int'($urandom_range(0, 4095)), card, lat);
        for (int r = 1; r <= 13; r++) chk("rank_tally", tally[r], 4);
        chk("drained_empty", int'(bus.o_Empty), 1);
        chk("drained_remaining", int'(bus.o_Remaining), 0);

        bus.i_Count = W'(7);
        bus.i_Draw  = 1'b1;
        watch(30, 1'b0, 0, 0, 0, n, lat);
        chk("draw_when_empty_valids", n, 0);
        chk("draw_when_empty_busy", int'(bus.o_Busy), 0);

        bus.i_NewDeck = 1'b1;
        watch(2, 1'b0, 0, 0, 0, n, lat);
        model_refill();
        chk_idle_refilled("newdeck");

        // Second draw while busy is ignored.
        bus.i_Count = W'(100);
        bus.i_Draw  = 1'b1;
        sb.push_back(model_draw(100));
        watch(40, 1'b0, 5, 0, 0, n, lat);
        chk("double_draw_valids", n, 1);

        // Refill mid-draw aborts it.
        bus.i_Count = W'(33);
        bus.i_Draw  = 1'b1;
        watch(30, 1'b0, 0, 6, 0, n, lat);
        model_refill();
        chk("abort_valids", n, 0);
        chk_idle_refilled("abort");

        // Draw and refill together: refill wins.
        do_draw(50, card, lat);
        bus.i_Count   = W'(51);
        bus.i_Draw    = 1'b1;
        bus.i_NewDeck = 1'b1;
        watch(30, 1'b0, 0, 0, 0, n, lat);
        model_refill();
        chk("draw_newdeck_valids", n, 0);
        chk_idle_refilled("draw_newdeck");

        // Reset mid-draw.
        do_draw(60, card, lat);
        bus.i_Count = W'(61);
        bus.i_Draw  = 1'b1;
        watch(30, 1'b0, 0, 0, 8, n, lat);
        model_refill();
        chk("reset_mid_valids", n, 0);
        chk_idle_refilled("reset_mid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
